// File: rtl/div_tick_pkg.sv
// Shared encodings for the divided-clock tick generator: source selects and
// handshake FSM states.
package div_tick_pkg;

    localparam logic [1:0] SEL_DIV2 = 2'd0;
    localparam logic [1:0] SEL_DIV4 = 2'd1;
    localparam logic [1:0] SEL_DIV8 = 2'd2;
    localparam logic [1:0] SEL_EXT  = 2'd3;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

endpackage

// File: rtl/div_tick_gen_rise_detect.sv
// One-bit rising-edge detector for a clk-synchronous level: the history
// register clears on reset, so a level already high reads as a rise.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic lvl_i,
    output logic rise_o
);

    logic lvl_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_q <= 1'b0;
        end else begin
            lvl_q <= lvl_i;
        end
    end

    assign rise_o = lvl_i & ~lvl_q;

endmodule

// File: rtl/div_tick_gen.sv
// Turns the selected divider level into single-cycle clk enables; rate
// changes are handshaked in and applied only on a divideby8 rising boundary.
module div_tick_gen
    import div_tick_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int EXT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             divideby2,
    input  logic             divideby4,
    input  logic             divideby8,
    input  logic [1:0]       sel_req,
    input  logic             sel_valid,
    output logic             sel_ready,
    output logic             pending,
    output logic [1:0]       active_sel,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count
);

    localparam logic [7:0] EXT_LAST = 8'(EXT_DIV - 1);

    logic rise2, rise4, rise8;

    rise_detect u_rise2 (.clk(clk), .rst(rst), .lvl_i(divideby2), .rise_o(rise2));
    rise_detect u_rise4 (.clk(clk), .rst(rst), .lvl_i(divideby4), .rise_o(rise4));
    rise_detect u_rise8 (.clk(clk), .rst(rst), .lvl_i(divideby8), .rise_o(rise8));

    state_e           state_q;
    logic [1:0]       pend_sel_q;
    logic [1:0]       active_q;
    logic             ready_q;
    logic             pending_q;
    logic [7:0]       ext_q, ext_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             src_rise;
    logic             ext_wrap;
    logic             switch_now;

    // Source rise uses the old active_q even in the switch cycle.
    always_comb begin
        ext_wrap   = rise8 && (ext_q == EXT_LAST);
        switch_now = (state_q == ST_PENDING) && rise8;
        case (active_q)
            SEL_DIV2: src_rise = rise2;
            SEL_DIV4: src_rise = rise4;
            SEL_DIV8: src_rise = rise8;
            default:  src_rise = ext_wrap;
        endcase

        ext_d = ext_q;
        if (switch_now || (active_q != SEL_EXT)) begin
            ext_d = '0;
        end else if (rise8) begin
            ext_d = ext_wrap ? 8'd0 : ext_q + 8'd1;
        end

        tick_d = src_rise;
        cnt_d  = src_rise ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_q  <= '0;
            tick_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            ext_q  <= ext_d;
            tick_q <= tick_d;
            cnt_q  <= cnt_d;
        end
    end

    // Handshake FSM; requests arriving while PENDING are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            pend_sel_q <= SEL_DIV2;
            active_q   <= SEL_DIV2;
            ready_q    <= 1'b1;
            pending_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (sel_valid && ready_q) begin
                        pend_sel_q <= sel_req;
                        state_q    <= ST_PENDING;
                        ready_q    <= 1'b0;
                        pending_q  <= 1'b1;
                    end
                end
                default: begin
                    if (rise8) begin
                        active_q  <= pend_sel_q;
                        state_q   <= ST_RUN;
                        ready_q   <= 1'b1;
                        pending_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign sel_ready  = ready_q;
    assign pending    = pending_q;
    assign active_sel = active_q;
    assign tick       = tick_q;
    assign tick_count = cnt_q;

endmodule
